rsa_modexp_unit: RTL and testbench

- Parametrised sequential modular-exponentiation engine. Computes result = base^exp mod modulus.
- It is the shared next-generation datapath for the RSA encrypt and decrypt stages, replacing their separate fixed-width exponentiators.
- Uses left-to-right square-and-multiply over interleaved shift-add modular multiplication.
- Reports the cycle count of every operation so the timing side-channel bench can measure leakage.

---
 rtl/rsa_modexp_unit_if.sv | 26 ++
 rtl/rsa_modexp_unit.sv | 150 +++++++++++++++
 tb/tb_rsa_modexp_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_unit_if.sv
// Operand/result bundle for rsa_modexp_unit: request side (master) and engine side (slave).
interface rsa_modexp_unit_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EXP_WIDTH = 16,
    parameter int unsigned CNT_W     = 24
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exp;
    logic [WIDTH-1:0]     modulus;
    logic                 ready;
    logic                 done;
    logic                 err;
    logic [WIDTH-1:0]     result;
    logic [CNT_W-1:0]     cycle_count;

    modport master (
        output start, base, exp, modulus,
        input  ready, done, err, result, cycle_count
    );

    modport slave (
        input  start, base, exp, modulus,
        output ready, done, err, result, cycle_count
    );
endinterface

// File: rtl/rsa_modexp_unit.sv
// Left-to-right square-and-multiply modular exponentiation with per-operation cycle count.
// Define RSA_CONST_TIME_EN to run the multiply for every exponent bit (exponent-independent timing).
module rsa_modexp_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EXP_WIDTH = 16,
    parameter int unsigned CNT_W     = 24
) (
    input logic              clk,
    input logic              rst_n,
    rsa_modexp_unit_if.slave bus
);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned JW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StCheck, StSqr, StMul, StDone} state_e;

    state_e               r_state, w_state_next;
    logic [WIDTH-1:0]     r_base, r_mod, r_acc, r_result;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [JW-1:0]        r_j;
    logic [IW-1:0]        r_i;
    logic [WIDTH+1:0]     r_p;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt, r_cycle_count;

    logic                 w_accept, w_op_err, w_last, w_exp_bit, w_do_mul, w_last_bit;
    logic                 w_bit_end;
    logic [WIDTH-1:0]     w_mul_b, w_acc_upd;
    logic [WIDTH+1:0]     w_n, w_p_dbl, w_p_red, w_p_add, w_p_next;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_accept   = bus.start && (r_state == StIdle);
    assign w_op_err   = (r_mod < WIDTH'(2)) || (r_base >= r_mod);
    assign w_last     = (r_i == '0);
    assign w_exp_bit  = r_exp[r_j];
    assign w_last_bit = (r_j == '0);
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
`ifdef RSA_CONST_TIME_EN
    assign w_do_mul   = 1'b1;
`else
    assign w_do_mul   = w_exp_bit;
`endif
    // Last multiply cycle that also finishes the current exponent bit
    assign w_bit_end  = w_last && ((r_state == StMul) || ((r_state == StSqr) && !w_do_mul));

    // One interleaved shift-add step; p stays below n after each step
    always_comb begin
        w_mul_b   = (r_state == StMul) ? r_base : r_acc;
        w_n       = {2'b00, r_mod};
        w_p_dbl   = r_p << 1;
        w_p_red   = (w_p_dbl >= w_n) ? w_p_dbl - w_n : w_p_dbl;
        w_p_add   = w_mul_b[r_i] ? w_p_red + {2'b00, r_acc} : w_p_red;
        w_p_next  = (w_p_add >= w_n) ? w_p_add - w_n : w_p_add;
        w_acc_upd = w_p_next[WIDTH-1:0];
`ifdef RSA_CONST_TIME_EN
        // Dummy multiply for a zero bit: product stays in r_p and is dropped
        if ((r_state == StMul) && !w_exp_bit) begin
            w_acc_upd = r_acc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = StCheck;
            StCheck: w_state_next = w_op_err ? StDone : StSqr;
            StSqr: begin
                if (w_last) begin
                    if (w_do_mul)        w_state_next = StMul;
                    else if (w_last_bit) w_state_next = StDone;
                    else                 w_state_next = StSqr;
                end
            end
            StMul:   if (w_last) w_state_next = w_last_bit ? StDone : StSqr;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.ready = (r_state == StIdle);
        bus.done  = (r_state == StDone);
    end

    assign bus.err         = r_err;
    assign bus.result      = r_result;
    assign bus.cycle_count = r_cycle_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_exp         <= '0;
            r_mod         <= '0;
            r_acc         <= '0;
            r_p           <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_result      <= '0;
            r_cycle_count <= '0;
        end else begin
            // r_cnt holds the index of the current cycle, start cycle being 0
            if (w_accept) begin
                r_base <= bus.base;
                r_exp  <= bus.exp;
                r_mod  <= bus.modulus;
                r_cnt  <= CNT_W'(1);
            end else if ((r_state != StIdle) && (r_state != StDone)) begin
                r_cnt <= w_cnt_inc;
            end

            if (r_state == StCheck) begin
                r_acc <= WIDTH'(1);
                r_j   <= JW'(EXP_WIDTH - 1);
                r_i   <= IW'(WIDTH - 1);
                r_p   <= '0;
            end

            if ((r_state == StSqr) || (r_state == StMul)) begin
                if (w_last) begin
                    r_p   <= '0;
                    r_i   <= IW'(WIDTH - 1);
                    r_acc <= w_acc_upd;
                    if (w_bit_end && !w_last_bit) begin
                        r_j <= r_j - JW'(1);
                    end
                end else begin
                    r_p <= w_p_next;
                    r_i <= r_i - IW'(1);
                end
            end

            if (w_state_next == StDone) begin
                r_err         <= (r_state == StCheck);
                r_result      <= (r_state == StCheck) ? '0 : w_acc_upd;
                r_cycle_count <= w_cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Self-checking bench for rsa_modexp_unit: directed scenarios plus random operands
// compared against a plain-arithmetic modexp and latency model.
module tb_rsa_modexp_unit;
    localparam int unsigned W     = 16;
    localparam int unsigned EW    = 16;
    localparam int unsigned CW    = 24;
    localparam int          LIMIT = 2000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rsa_modexp_unit_if #(.WIDTH(W), .EXP_WIDTH(EW), .CNT_W(CW)) bus_if ();

    rsa_modexp_unit #(.WIDTH(W), .EXP_WIDTH(EW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit ref_err(input longint unsigned b, input longint unsigned n);
        return (n < 2) || (b >= n);
    endfunction

    function automatic longint unsigned ref_modexp(input longint unsigned b,
                                                   input longint unsigned e,
                                                   input longint unsigned n);
        longint unsigned r;
        if (ref_err(b, n)) return 0;
        r = 1;
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (((e >> i) & 1) == 1) r = (r * b) % n;
        end
        return r;
    endfunction

    function automatic longint unsigned ref_lat(input longint unsigned b,
                                                input longint unsigned e,
                                                input longint unsigned n);
        longint unsigned l;
        longint unsigned pop;
        pop = 0;
        for (int i = 0; i < EW; i++) pop += (e >> i) & 1;
        if (ref_err(b, n)) return 2;
`ifdef RSA_CONST_TIME_EN
        l = 2 + 2 * W * EW + 0 * pop;
`else
        l = 2 + W * (EW + pop);
`endif
        if (l > (64'd1 << CW) - 1) l = (64'd1 << CW) - 1;
        return l;
    endfunction

    // Drives start for one cycle; returns at the negedge of cycle 1
    task automatic launch(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n);
        @(negedge clk);
        bus_if.base    = b;
        bus_if.exp     = e;
        bus_if.modulus = n;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (bus_if.done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (bus_if.done !== 1'b1) lat = -1;
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] b, input logic [EW-1:0] e,
                             input logic [W-1:0] n);
        int lat;
        launch(b, e, n);
        chk({tag, ".ready_drop"}, bus_if.ready, 0);
        wait_done(1, lat);
        chk({tag, ".latency"}, lat, ref_lat(b, e, n));
        chk({tag, ".result"}, bus_if.result, ref_modexp(b, e, n));
        chk({tag, ".err"}, bus_if.err, ref_err(b, n));
        chk({tag, ".cycle_count"}, bus_if.cycle_count, ref_lat(b, e, n));
        @(negedge clk);
        chk({tag, ".done_pulse"}, bus_if.done, 0);
        chk({tag, ".ready_back"}, bus_if.ready, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat2;
        logic [W-1:0]  rb, rn;
        logic [EW-1:0] re;
        longint unsigned cc_lo;

        rst_n          = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.base    = '0;
        bus_if.exp     = '0;
        bus_if.modulus = '0;
        repeat (3) @(negedge clk);
        chk("reset.ready", bus_if.ready, 1);
        chk("reset.done", bus_if.done, 0);
        chk("reset.err", bus_if.err, 0);
        chk("reset.result", bus_if.result, 0);
        chk("reset.cycle_count", bus_if.cycle_count, 0);
        rst_n = 1'b1;

        run_check("tp1", 16'd4, 16'd13, 16'd497);
        chk("tp1.known_result", bus_if.result, 445);
`ifdef RSA_CONST_TIME_EN
        chk("tp1.known_cc", bus_if.cycle_count, 514);
`else
        chk("tp1.known_cc", bus_if.cycle_count, 306);
`endif

        run_check("tp2.enc", 16'd65, 16'd17, 16'd3233);
        chk("tp2.enc_known", bus_if.result, 2790);
        run_check("tp2.dec", 16'd2790, 16'd2753, 16'd3233);
        chk("tp2.dec_known", bus_if.result, 65);

        run_check("tp3.exp0", 16'd7, 16'd0, 16'd11);
        chk("tp3.exp0_known", bus_if.result, 1);
        run_check("tp3.base_ge_mod", 16'd12, 16'd5, 16'd11);
        chk("tp3.base_ge_mod_err", bus_if.err, 1);
        run_check("tp3.mod1", 16'd0, 16'd5, 16'd1);
        run_check("tp3.mod0", 16'd0, 16'd5, 16'd0);

        run_check("tp5.exp1", 16'd5, 16'h0001, 16'd11);
        cc_lo = bus_if.cycle_count;
        run_check("tp5.expffff", 16'd5, 16'hFFFF, 16'd11);
`ifdef RSA_CONST_TIME_EN
        chk("tp5.cc_lo_known", cc_lo, 514);
`else
        chk("tp5.cc_lo_known", cc_lo, 274);
`endif
        chk("tp5.cc_hi_known", bus_if.cycle_count, 514);

        // Start pulsed mid-operation must be ignored
        launch(16'd4, 16'd13, 16'd497);
        repeat (99) @(negedge clk);
        bus_if.base    = 16'd2;
        bus_if.exp     = 16'd3;
        bus_if.modulus = 16'd7;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
        wait_done(101, lat);
        chk("tp4.busy_latency", lat, ref_lat(4, 13, 497));
        chk("tp4.busy_result", bus_if.result, 445);
        chk("tp4.busy_err", bus_if.err, 0);

        // Reset mid-operation
        launch(16'd65, 16'd17, 16'd3233);
        repeat (149) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("tp4.rst_ready", bus_if.ready, 1);
        chk("tp4.rst_done", bus_if.done, 0);
        chk("tp4.rst_err", bus_if.err, 0);
        chk("tp4.rst_result", bus_if.result, 0);
        chk("tp4.rst_cycle_count", bus_if.cycle_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("tp4.after_rst", 16'd3, 16'd5, 16'd13);

        // start held high across two operations
        @(negedge clk);
        bus_if.base    = 16'd65;
        bus_if.exp     = 16'd17;
        bus_if.modulus = 16'd3233;
        bus_if.start   = 1'b1;
        @(negedge clk);
        wait_done(1, lat);
        chk("tp6.first_latency", lat, ref_lat(65, 17, 3233));
        chk("tp6.first_result", bus_if.result, 2790);
        bus_if.base    = 16'd2790;
        bus_if.exp     = 16'd2753;
        @(negedge clk);
        chk("tp6.idle_ready", bus_if.ready, 1);
        @(negedge clk);
        chk("tp6.accepted", bus_if.ready, 0);
        bus_if.start   = 1'b0;
        chk("tp6.hold_early", bus_if.result, 2790);
        repeat (50) @(negedge clk);
        chk("tp6.hold_mid", bus_if.result, 2790);
        wait_done(51, lat2);
        chk("tp6.second_latency", lat2, ref_lat(2790, 2753, 3233));
        chk("tp6.second_result", bus_if.result, 65);

        for (int k = 0; k < 8; k++) begin
            rn = W'($urandom_range(2, 65535));
            if (k % 4 == 3) rb = W'($urandom_range(rn, 65535));
            else            rb = W'($urandom_range(0, rn - 1));
            re = EW'($urandom_range(0, 65535));
            run_check($sformatf("rand%0d", k), rb, re, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
